// File: rtl/axi4l_regfile_if.sv
// AXI4-Lite bus bundle for the generic register file: the five AXI4-Lite
// channels, with master and slave views.
interface axi4l_regfile_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi4l_regfile.sv
// Generic AXI4-Lite register file. C_NUM_REGS word-spaced registers, each
// either read-write (held here, driven on reg_out) or read-only (sampled from
// reg_in at read time). Byte-strobe writes, per-register access strobes, and
// SLVERR/DECERR responses. Read and write paths run independently.
module axi4l_regfile #(
   parameter int                                 C_ADDR_WIDTH = 12,
   parameter int                                 C_DATA_WIDTH = 32,
   parameter int                                 C_NUM_REGS   = 16,
   parameter logic [C_NUM_REGS-1:0]              C_RW_MASK    = '1,
   parameter logic [C_NUM_REGS*C_DATA_WIDTH-1:0] C_RST_VAL    = '0
) (
   input  logic                                 aclk,
   input  logic                                 aresetn,
   axi4l_regfile_if.slave                       s_axi,
   output logic [C_NUM_REGS*C_DATA_WIDTH-1:0]   reg_out,
   input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0]   reg_in,
   output logic [C_NUM_REGS-1:0]                wr_stb,
   output logic [C_NUM_REGS-1:0]                rd_stb
);

   localparam int ADDR_LSB = (C_DATA_WIDTH == 64) ? 3 : 2;
   localparam int STRB_W   = C_DATA_WIDTH / 8;
   localparam int IDX_W    = C_ADDR_WIDTH - ADDR_LSB;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   if (C_DATA_WIDTH != 32 && C_DATA_WIDTH != 64) begin : g_bad_data_width
      $error("axi4l_regfile: C_DATA_WIDTH must be 32 or 64");
   end
   if (C_NUM_REGS < 1 || C_NUM_REGS > 256) begin : g_bad_num_regs
      $error("axi4l_regfile: C_NUM_REGS must be 1..256");
   end
   if (C_ADDR_WIDTH < ADDR_LSB + $clog2(C_NUM_REGS)) begin : g_bad_addr_width
      $error("axi4l_regfile: C_ADDR_WIDTH too small for C_NUM_REGS");
   end

   typedef enum logic [1:0] {W_IDLE, W_HAVEA, W_HAVED, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_RESP}                   r_state_e;

   // One-hot register select; an unmapped word index yields all zeros.
   function automatic logic [C_NUM_REGS-1:0] decode(input logic [IDX_W-1:0] idx);
      logic [C_NUM_REGS-1:0] sel;
      sel = '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
         sel[i] = (idx == IDX_W'(i));
      end
      return sel;
   endfunction

   w_state_e                w_state_q, w_state_d;
   r_state_e                r_state_q, r_state_d;
   logic                    ready_en_q;
   logic                    aw_fire, w_fire, ar_fire;
   logic [IDX_W-1:0]        aw_idx_q;
   logic [C_DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]       wstrb_q;
   logic [IDX_W-1:0]        wr_idx;
   logic [C_DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]       wr_strb;
   logic                    wr_commit;
   logic [C_NUM_REGS-1:0]   wr_sel;
   logic [C_NUM_REGS-1:0]   rd_sel;
   logic [C_DATA_WIDTH-1:0] rd_src [C_NUM_REGS];
   logic [C_DATA_WIDTH-1:0] rd_data;
   logic                    unused_bits;

   // Protocol fields and address offset bits carry no meaning here; RW slices
   // of reg_in are ignored by design.
   assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                          s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0],
                          reg_in};

   // Hold all readies low until the first clock after reset is released.
   always_ff @(posedge aclk) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values, which is what makes same-edge read/write ordering exact.
      if (!aresetn) ready_en_q <= 1'b0;
      else          ready_en_q <= 1'b1;
   end

   assign s_axi.awready = ready_en_q && (w_state_q == W_IDLE || w_state_q == W_HAVED);
   assign s_axi.wready  = ready_en_q && (w_state_q == W_IDLE || w_state_q == W_HAVEA);
   assign s_axi.bvalid  = (w_state_q == W_RESP);
   assign s_axi.arready = ready_en_q && (r_state_q == R_IDLE);
   assign s_axi.rvalid  = (r_state_q == R_RESP);

   assign aw_fire = s_axi.awvalid & s_axi.awready;
   assign w_fire  = s_axi.wvalid  & s_axi.wready;
   assign ar_fire = s_axi.arvalid & s_axi.arready;

   // Write FSM state register.
   always_ff @(posedge aclk) begin
      if (!aresetn) w_state_q <= W_IDLE;
      else          w_state_q <= w_state_d;
   end

   // Write FSM next state, commit strobe and write operand selection
   // (address/data come from the latch if that half arrived earlier).
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves a latch.
      w_state_d = w_state_q;
      wr_commit = 1'b0;
      wr_idx    = (w_state_q == W_HAVEA) ? aw_idx_q : s_axi.awaddr[C_ADDR_WIDTH-1:ADDR_LSB];
      wr_data   = (w_state_q == W_HAVED) ? wdata_q  : s_axi.wdata;
      wr_strb   = (w_state_q == W_HAVED) ? wstrb_q  : s_axi.wstrb;
      case (w_state_q)
         W_IDLE: begin
            if (aw_fire && w_fire) begin
               w_state_d = W_RESP;
               wr_commit = 1'b1;
            end else if (aw_fire) begin
               w_state_d = W_HAVEA;
            end else if (w_fire) begin
               w_state_d = W_HAVED;
            end
         end
         W_HAVEA: begin
            if (w_fire) begin
               w_state_d = W_RESP;
               wr_commit = 1'b1;
            end
         end
         W_HAVED: begin
            if (aw_fire) begin
               w_state_d = W_RESP;
               wr_commit = 1'b1;
            end
         end
         W_RESP: begin
            if (s_axi.bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   assign wr_sel = decode(wr_idx);

   // Latch whichever write half arrives first; register response and strobe
   // on the commit edge so they align with the first bvalid cycle.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         aw_idx_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         s_axi.bresp <= RESP_OKAY;
         wr_stb      <= '0;
      end else begin
         wr_stb <= '0;
         if (aw_fire) aw_idx_q <= s_axi.awaddr[C_ADDR_WIDTH-1:ADDR_LSB];
         if (w_fire) begin
            wdata_q <= s_axi.wdata;
            wstrb_q <= s_axi.wstrb;
         end
         if (wr_commit) begin
            wr_stb <= wr_sel & C_RW_MASK;
            if (!(|wr_sel))                 s_axi.bresp <= RESP_DECERR;
            else if (|(wr_sel & C_RW_MASK)) s_axi.bresp <= RESP_OKAY;
            else                            s_axi.bresp <= RESP_SLVERR;
         end
      end
   end

   // Register storage: flops exist only for RW registers.
   for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
      if (C_RW_MASK[i]) begin : g_rw
         logic [C_DATA_WIDTH-1:0] q;
         // Byte-masked update of one RW register on its commit edge.
         always_ff @(posedge aclk) begin
            // NOTE: this is a flop bank with per-register reset values, not a
            // RAM, so resetting every entry is both legal and required.
            if (!aresetn) begin
               q <= C_RST_VAL[i*C_DATA_WIDTH +: C_DATA_WIDTH];
            end else if (wr_commit && wr_sel[i]) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (wr_strb[b]) q[b*8 +: 8] <= wr_data[b*8 +: 8];
               end
            end
         end
         assign reg_out[i*C_DATA_WIDTH +: C_DATA_WIDTH] = q;
         assign rd_src[i] = q;
      end else begin : g_ro
         assign reg_out[i*C_DATA_WIDTH +: C_DATA_WIDTH] = '0;
         assign rd_src[i] = reg_in[i*C_DATA_WIDTH +: C_DATA_WIDTH];
      end
   end

   assign rd_sel = decode(s_axi.araddr[C_ADDR_WIDTH-1:ADDR_LSB]);

   // Read mux: OR of the selected source; unmapped selects nothing -> zero.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
         if (rd_sel[i]) rd_data = rd_data | rd_src[i];
      end
   end

   // Read FSM state register.
   always_ff @(posedge aclk) begin
      if (!aresetn) r_state_q <= R_IDLE;
      else          r_state_q <= r_state_d;
   end

   // Read FSM next state: accept an address, then hold until rready.
   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE:  if (ar_fire)      r_state_d = R_RESP;
         R_RESP:  if (s_axi.rready) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // Capture read data/response on the accept edge; held until the next accept.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         s_axi.rdata <= '0;
         s_axi.rresp <= RESP_OKAY;
         rd_stb      <= '0;
      end else begin
         rd_stb <= '0;
         if (ar_fire) begin
            s_axi.rdata <= rd_data;
            s_axi.rresp <= (|rd_sel) ? RESP_OKAY : RESP_DECERR;
            rd_stb      <= rd_sel;
         end
      end
   end

endmodule

// File: tb/tb_axi4l_regfile.sv
// Self-checking bench for axi4l_regfile: directed scenarios plus a random
// mix, all checked against a per-register behavioural model.
`timescale 1ns/1ps
module tb_axi4l_regfile;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int NR = 16;
   localparam int SW = DW / 8;
   localparam int VW = NR * DW;
   localparam logic [NR-1:0] RW_MASK = 16'hFFF7;   // register 3 is read-only
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

   function automatic logic [VW-1:0] make_rst();
      logic [VW-1:0] v;
      v = '0;
      for (int i = 0; i < NR; i++) begin
         if (i != 2) v[i*DW +: DW] = 32'hA5A5_0000 | DW'(i);
      end
      return v;
   endfunction
   localparam logic [VW-1:0] RST_VAL = make_rst();

   logic          aclk;
   logic          aresetn;
   logic [VW-1:0] reg_out;
   logic [VW-1:0] reg_in;
   logic [NR-1:0] wr_stb;
   logic [NR-1:0] rd_stb;

   axi4l_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   axi4l_regfile #(
      .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_NUM_REGS(NR),
      .C_RW_MASK(RW_MASK), .C_RST_VAL(RST_VAL)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .s_axi(axi),
      .reg_out(reg_out), .reg_in(reg_in), .wr_stb(wr_stb), .rd_stb(rd_stb)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Behavioural model: register contents and RO sources.
   logic [DW-1:0] m_regs [NR];
   logic [DW-1:0] m_in   [NR];

   always_comb begin
      for (int i = 0; i < NR; i++) reg_in[i*DW +: DW] = m_in[i];
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic int widx(input logic [AW-1:0] a);
      return int'(a[AW-1:2]);
   endfunction

   function automatic logic [1:0] m_wresp(input int idx);
      if (idx >= NR)         return DECERR;
      else if (!RW_MASK[idx]) return SLVERR;
      else                   return OKAY;
   endfunction

   function automatic logic [DW-1:0] m_rdata(input int idx);
      if (idx >= NR)   return '0;
      if (RW_MASK[idx]) return m_regs[idx];
      return m_in[idx];
   endfunction

   function automatic logic [VW-1:0] m_reg_out();
      logic [VW-1:0] v;
      v = '0;
      for (int i = 0; i < NR; i++) if (RW_MASK[i]) v[i*DW +: DW] = m_regs[i];
      return v;
   endfunction

   task automatic m_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb);
      int idx;
      idx = widx(addr);
      if (m_wresp(idx) == OKAY) begin
         for (int b = 0; b < SW; b++) if (strb[b]) m_regs[idx][b*8 +: 8] = data[b*8 +: 8];
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = RST_VAL[i*DW +: DW];
   endtask

   // Present any combination of AW/W/AR and wait (bounded) for their handshakes.
   task automatic issue(input bit do_aw, input bit do_w, input bit do_ar,
                        input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                        input logic [SW-1:0] wstrb, input logic [AW-1:0] raddr);
      bit aw_p, w_p, ar_p, aw_h, w_h, ar_h;
      int n;
      aw_p = do_aw; w_p = do_w; ar_p = do_ar; n = 0;
      axi.awaddr = waddr; axi.wdata = wdata; axi.wstrb = wstrb; axi.araddr = raddr;
      axi.awvalid = aw_p; axi.wvalid = w_p; axi.arvalid = ar_p;
      while ((aw_p || w_p || ar_p) && n < 20) begin
         aw_h = aw_p && axi.awready;
         w_h  = w_p  && axi.wready;
         ar_h = ar_p && axi.arready;
         tick();
         if (aw_h) begin aw_p = 0; axi.awvalid = 1'b0; end
         if (w_h)  begin w_p  = 0; axi.wvalid  = 1'b0; end
         if (ar_h) begin ar_p = 0; axi.arvalid = 1'b0; end
         n++;
      end
      check("handshake_timeout", {aw_p, w_p, ar_p}, '0);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
   endtask

   // Collect a write response, optionally stalling bready for 'hold' cycles
   // while offering a new write that must not be accepted.
   task automatic wait_b(input logic [1:0] exp_resp, input logic [NR-1:0] exp_stb, input int hold);
      int n;
      n = 0;
      while (!axi.bvalid && n < 20) begin tick(); n++; end
      check("bvalid", axi.bvalid, 1);
      check("bresp", axi.bresp, exp_resp);
      check("wr_stb", wr_stb, exp_stb);
      check("reg_out", reg_out, m_reg_out());
      for (int k = 0; k < hold; k++) begin
         axi.awaddr = 12'h018; axi.wdata = 32'h5555_AAAA; axi.wstrb = 4'hF;
         axi.awvalid = 1'b1; axi.wvalid = 1'b1;
         tick();
         check("b_hold_valid", axi.bvalid, 1);
         check("b_hold_resp", axi.bresp, exp_resp);
         check("b_hold_ready", {axi.awready, axi.wready}, 2'b00);
         check("b_hold_stb", wr_stb, '0);
      end
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      axi.bready = 1'b1;
      tick();
      axi.bready = 1'b0;
      check("bvalid_drop", axi.bvalid, 0);
      check("wr_stb_clear", wr_stb, '0);
      check("ready_after_b", {axi.awready, axi.wready}, 2'b11);
      check("reg_out_after_b", reg_out, m_reg_out());
   endtask

   // gap = 0: AW and W together; gap > 0: AW leads W by gap cycles;
   // gap < 0: W leads AW by -gap cycles.
   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input int gap, input int hold);
      int idx;
      logic [1:0] resp;
      logic [NR-1:0] stb;
      idx  = widx(addr);
      resp = m_wresp(idx);
      stb  = (resp == OKAY) ? (NR'(1) << idx) : '0;
      if (gap == 0) begin
         issue(1, 1, 0, addr, data, strb, '0);
      end else if (gap > 0) begin
         issue(1, 0, 0, addr, data, strb, '0);
         check("havea_ready", {axi.awready, axi.wready, axi.bvalid}, 3'b010);
         repeat (gap - 1) tick();
         issue(0, 1, 0, addr, data, strb, '0);
      end else begin
         issue(0, 1, 0, addr, data, strb, '0);
         check("haved_ready", {axi.awready, axi.wready, axi.bvalid}, 3'b100);
         repeat (-gap - 1) tick();
         issue(1, 0, 0, addr, data, strb, '0);
      end
      m_write(addr, data, strb);
      wait_b(resp, stb, hold);
   endtask

   // Read with rready stalled 'hold' cycles; the RO source and AR bus change
   // meanwhile and must not disturb the held response.
   task automatic do_read(input logic [AW-1:0] addr, input int hold);
      int idx, n;
      logic [DW-1:0] exp_data;
      logic [1:0] exp_resp;
      logic [NR-1:0] exp_stb;
      idx      = widx(addr);
      exp_data = m_rdata(idx);
      exp_resp = (idx < NR) ? OKAY : DECERR;
      exp_stb  = (idx < NR) ? (NR'(1) << idx) : '0;
      issue(0, 0, 1, '0, '0, '0, addr);
      n = 0;
      while (!axi.rvalid && n < 20) begin tick(); n++; end
      check("rvalid", axi.rvalid, 1);
      check("rdata", axi.rdata, exp_data);
      check("rresp", axi.rresp, exp_resp);
      check("rd_stb", rd_stb, exp_stb);
      for (int k = 0; k < hold; k++) begin
         m_in[3] = $urandom;
         axi.araddr = 12'h010; axi.arvalid = 1'b1;
         tick();
         check("r_hold_valid", axi.rvalid, 1);
         check("r_hold_data", axi.rdata, exp_data);
         check("r_hold_resp", axi.rresp, exp_resp);
         check("r_hold_arready", axi.arready, 0);
         check("r_hold_stb", rd_stb, '0);
      end
      axi.arvalid = 1'b0;
      axi.rready = 1'b1;
      tick();
      axi.rready = 1'b0;
      check("rvalid_drop", axi.rvalid, 0);
      check("rd_stb_clear", rd_stb, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] old0;
      axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
      axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
      axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
      for (int i = 0; i < NR; i++) m_in[i] = $urandom;
      m_in[3] = 32'hCAFE_0003;
      m_reset();

      // Reset state and ready release timing.
      aresetn = 1'b0;
      repeat (3) tick();
      check("rst_ready", {axi.awready, axi.wready, axi.arready}, 3'b000);
      check("rst_valid", {axi.bvalid, axi.rvalid}, 2'b00);
      check("rst_resp", {axi.bresp, axi.rresp}, 4'b0000);
      check("rst_rdata", axi.rdata, '0);
      check("rst_stb", {wr_stb, rd_stb}, '0);
      check("rst_reg_out", reg_out, m_reg_out());
      aresetn = 1'b1;
      check("ready_still_low", {axi.awready, axi.wready, axi.arready}, 3'b000);
      tick();
      check("ready_rise", {axi.awready, axi.wready, axi.arready}, 3'b111);

      // Read every register after reset.
      for (int i = 0; i < NR; i++) do_read(AW'(i * 4), 0);

      // AW and W together.
      do_write(12'h004, 32'hDEAD_BEEF, 4'hF, 0, 0);
      check("reg1_value", reg_out[1*DW +: DW], 32'hDEAD_BEEF);

      // W three cycles before AW, then AW two cycles before W; partial strobes.
      do_write(12'h008, 32'h1234_5678, 4'b0101, -3, 0);
      check("reg2_merge_wfirst", reg_out[2*DW +: DW], 32'h0034_0078);
      do_write(12'h008, 32'h1234_5678, 4'b0101, 2, 0);
      check("reg2_merge_afirst", reg_out[2*DW +: DW], 32'h0034_0078);

      // RO write -> SLVERR, unmapped write/read -> DECERR.
      do_write(12'h00C, 32'h0BAD_F00D, 4'hF, 0, 0);
      do_read(12'h00C, 0);
      do_write(12'h040, 32'h7777_7777, 4'hF, 0, 0);
      do_read(12'h040, 0);

      // Response back-pressure on both channels.
      do_write(12'h014, 32'hFEED_0014, 4'hF, 0, 5);
      do_read(12'h00C, 5);
      do_read(12'h018, 0);

      // Same-edge read and write of register 0 returns the pre-write value.
      do_write(12'h000, 32'd5, 4'hF, 0, 0);
      old0 = m_rdata(0);
      issue(1, 1, 1, 12'h000, 32'd9, 4'hF, 12'h000);
      check("concurrent_rvalid", axi.rvalid, 1);
      check("concurrent_rdata", axi.rdata, old0);
      m_write(12'h000, 32'd9, 4'hF);
      wait_b(OKAY, 16'h0001, 0);
      check("concurrent_rdata_held", axi.rdata, old0);
      axi.rready = 1'b1;
      tick();
      axi.rready = 1'b0;
      do_read(12'h000, 0);
      check("reg0_new", reg_out[0*DW +: DW], 32'd9);

      // Random mix of reads and writes, including unmapped indices and
      // random address offset bits.
      for (int it = 0; it < 60; it++) begin
         logic [AW-1:0] a;
         a = AW'($urandom_range(0, NR + 1) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) m_in[$urandom_range(0, NR - 1)] = $urandom;
         if ($urandom_range(0, 1) == 1)
            do_write(a, $urandom, SW'($urandom_range(0, 15)),
                     $urandom_range(0, 4) - 2, $urandom_range(0, 2));
         else
            do_read(a, $urandom_range(0, 2));
      end

      // Reset while the write FSM holds only an address: transaction dropped.
      issue(1, 0, 0, 12'h004, '0, '0, '0);
      check("havea_before_rst", {axi.awready, axi.wready}, 2'b01);
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
      m_reset();
      check("midrst_ready", {axi.awready, axi.wready, axi.arready}, 3'b000);
      check("midrst_reg_out", reg_out, m_reg_out());
      for (int k = 0; k < 4; k++) begin
         check("midrst_no_b", axi.bvalid, 0);
         tick();
      end
      do_write(12'h004, 32'hC0DE_0001, 4'hF, 0, 0);
      do_read(12'h004, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
